// File: rtl/instr_mem_server_pkg.sv
`default_nettype none
// ==== instr_mem_server_pkg : shared state encoding and constants (rev 1.0) ====
package instr_mem_server_pkg;

  localparam int unsigned DEFAULT_DEPTH = 64;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    LOAD   = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/instr_mem_server_ram.sv
`default_nettype none
// ==== instr_ram : instruction storage, one write port, one registered read port (rev 1.0) ====
module instr_ram #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [31:0]              wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Array contents are never reset so a loaded program survives reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/instr_mem_server.sv
`default_nettype none
// ==== instr_mem_server : IF-stage fetch server with program load port (rev 1.0) ====
module instr_mem_server
  import instr_mem_server_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  input  logic        fetch_flush,
  output logic        fetch_ack,
  output logic [31:0] fetch_data,
  output logic        fetch_err,
  input  logic        load_start,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  output logic        load_ready,
  output logic        load_done,
  output logic        busy
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);
  localparam logic [3:0]  CNT_INIT   = 4'(WAIT_CYCLES - 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          err_q, err_d;
  logic          ack_q, ack_d;
  logic          done_q, done_d;
  logic          ready_q;
  logic          busy_q;
  logic          ram_we;
  logic          ram_re;
  logic [31:0]   ram_rdata;
  logic          addr_bad;

  assign addr_bad = (addr_q[1:0] != 2'b00) || (addr_q >= ADDR_LIMIT);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    ram_we  = 1'b0;
    ram_re  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = LOAD;
          ptr_d   = '0;
        end else if (fetch_req && !fetch_flush) begin
          state_d = ACCESS;
          addr_d  = fetch_addr;
          cnt_d   = CNT_INIT;
        end
      end
      ACCESS: begin
        if (fetch_flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd0) begin
          // Ack is registered on entry to RESP, so a flush during RESP cannot cancel it.
          state_d = RESP;
          ram_re  = 1'b1;
          err_d   = addr_bad;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      LOAD: begin
        if (load_valid) begin
          ram_we = 1'b1;
          if (ptr_q == PTR_LAST) begin
            ptr_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      ready_q <= (state_d == LOAD);
      busy_q  <= (state_d != IDLE);
    end
  end

  instr_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (ram_we && reset),
    .waddr_i (ptr_q),
    .wdata_i (load_data),
    .re_i    (ram_re),
    .raddr_i (addr_q[AW+1:2]),
    .rdata_o (ram_rdata)
  );

  // Error responses substitute a NOP; both fields hold until the next response.
  assign fetch_data = err_q ? NOP_INSTR : ram_rdata;
  assign fetch_err  = err_q;
  assign fetch_ack  = ack_q;
  assign load_ready = ready_q;
  assign load_done  = done_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_server.sv
`default_nettype none
// ==== tb_instr_mem_server : scoreboard bench, one DUT at WAIT_CYCLES=1 and one at 3 (rev 1.0) ====
module tb_instr_mem_server;

  localparam int DEPTH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n [2];
  logic        req   [2];
  logic        flush [2];
  logic        ls    [2];
  logic        lv    [2];
  logic [31:0] addr  [2];
  logic [31:0] ld    [2];
  logic        ack   [2];
  logic        err   [2];
  logic        ready [2];
  logic        done  [2];
  logic        busy  [2];
  logic [31:0] data  [2];

  instr_mem_server #(.DEPTH(DEPTH), .WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .reset(rst_n[0]), .fetch_req(req[0]), .fetch_addr(addr[0]),
    .fetch_flush(flush[0]), .fetch_ack(ack[0]), .fetch_data(data[0]), .fetch_err(err[0]),
    .load_start(ls[0]), .load_valid(lv[0]), .load_data(ld[0]), .load_ready(ready[0]),
    .load_done(done[0]), .busy(busy[0])
  );

  instr_mem_server #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) u_dut_w3 (
    .clk(clk), .reset(rst_n[1]), .fetch_req(req[1]), .fetch_addr(addr[1]),
    .fetch_flush(flush[1]), .fetch_ack(ack[1]), .fetch_data(data[1]), .fetch_err(err[1]),
    .load_start(ls[1]), .load_valid(lv[1]), .load_data(ld[1]), .load_ready(ready[1]),
    .load_done(done[1]), .busy(busy[1])
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;
  int   ack_cnt [2] = '{0, 0};
  int   done_cnt[2] = '{0, 0};

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int qsize(int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic mon(int d);
    exp_t e;
    if (done[d] === 1'b1) done_cnt[d]++;
    if (ack[d] !== 1'b1) return;
    ack_cnt[d]++;
    if (qsize(d) == 0) begin
      chk($sformatf("unexpected_ack_dut%0d", d), 64'(ack[d]), 64'd0);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    chk($sformatf("ack_payload_dut%0d", d), 64'({err[d], data[d]}), 64'({e.err, e.data}));
    chk($sformatf("ack_latency_dut%0d", d), 64'(cyc), 64'(e.cyc));
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic chk_reset(int d, string name);
    chk(name, 64'({ack[d], err[d], ready[d], done[d], busy[d], data[d]}), 64'd0);
  endtask

  // Entry and exit: just after a rising edge. flush_at selects a cycle offset for fetch_flush.
  task automatic fetch(int d, logic [31:0] a, logic [31:0] ed, logic ee, int flush_at = -1);
    exp_t e;
    int   t;
    e.data = ed;
    e.err  = ee;
    e.cyc  = cyc + ((d == 0) ? 1 : 3) + 1;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    req[d]  = 1'b1;
    addr[d] = a;
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
      req[d]   = 1'b0;
      flush[d] = (t == flush_at);
    end while (qsize(d) != 0 && t < 40);
    flush[d] = 1'b0;
    if (qsize(d) != 0) begin
      chk($sformatf("fetch_timeout_dut%0d", d), 64'd1, 64'd0);
      if (d == 0) q0.delete();
      else        q1.delete();
    end
  endtask

  task automatic load(int d, logic [31:0] base, bit throttle, bit with_req);
    int n, k, rdy, dn, d0, a0;
    d0 = done_cnt[d];
    a0 = ack_cnt[d];
    ls[d] = 1'b1;
    if (with_req) begin
      req[d]  = 1'b1;
      addr[d] = 32'h8;
    end
    @(posedge clk); #1;
    ls[d] = 1'b0;
    req[d] = 1'b0;
    n = 0; k = 0; rdy = 0; dn = 0;
    while (n < DEPTH && k < 400) begin
      lv[d] = throttle ? (k % 2 == 0) : 1'b1;
      ld[d] = base + n;
      @(negedge clk);
      if (ready[d] === 1'b1) rdy++;
      if (done[d] === 1'b1)  dn++;
      @(posedge clk); #1;
      if (lv[d]) n++;
      k++;
    end
    lv[d] = 1'b0;
    chk($sformatf("load_ready_cycles_dut%0d", d), 64'(rdy), throttle ? 64'd127 : 64'd64);
    chk($sformatf("load_done_early_dut%0d", d), 64'(dn), 64'd0);
    @(negedge clk);
    chk($sformatf("load_end_flags_dut%0d", d), 64'({done[d], busy[d], ready[d]}), 64'b100);
    @(posedge clk); #1;
    fetch(d, 32'hFC, base + 32'd63, 1'b0);
    chk($sformatf("load_done_pulses_dut%0d", d), 64'(done_cnt[d] - d0), 64'd1);
    chk($sformatf("load_ack_count_dut%0d", d), 64'(ack_cnt[d] - a0), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    int   a0;
    tbl[0] = '{32'h0000_0008, 32'h1000_0002, 1'b0};
    tbl[1] = '{32'h0000_0000, 32'h1000_0000, 1'b0};
    tbl[2] = '{32'h0000_00FC, 32'h1000_003F, 1'b0};
    tbl[3] = '{32'h0000_0006, 32'h0000_0013, 1'b1};
    tbl[4] = '{32'h0000_0100, 32'h0000_0013, 1'b1};
    tbl[5] = '{32'h0000_0044, 32'h1000_0011, 1'b0};
    tbl[6] = '{32'h0000_00FD, 32'h0000_0013, 1'b1};
    tbl[7] = '{32'hFFFF_FFFC, 32'h0000_0013, 1'b1};

    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req[d] = 1'b0; flush[d] = 1'b0; ls[d] = 1'b0; lv[d] = 1'b0;
      addr[d] = '0; ld[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk_reset(0, "reset_outputs_dut0");
    chk_reset(1, "reset_outputs_dut1");
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    load(0, 32'h1000_0000, 1'b0, 1'b0);
    load(1, 32'h1000_0000, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) fetch(0, tbl[i].addr, tbl[i].data, tbl[i].err);

    // Flush in ACCESS, then a request in the very next cycle.
    a0 = ack_cnt[0];
    req[0] = 1'b1; addr[0] = 32'h10;
    @(posedge clk); #1; req[0] = 1'b0; flush[0] = 1'b1;
    @(posedge clk); #1; flush[0] = 1'b0;
    fetch(0, 32'h0C, 32'h1000_0003, 1'b0);
    chk("flush_access_ack_count", 64'(ack_cnt[0] - a0), 64'd1);

    // Flush in IDLE suppresses a simultaneous request.
    a0 = ack_cnt[0];
    req[0] = 1'b1; flush[0] = 1'b1; addr[0] = 32'h14;
    @(posedge clk); #1; req[0] = 1'b0; flush[0] = 1'b0;
    @(negedge clk);
    chk("flush_idle_busy", 64'(busy[0]), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("flush_idle_ack_count", 64'(ack_cnt[0] - a0), 64'd0);

    // Flush in RESP does not cancel the committed ack.
    fetch(0, 32'h18, 32'h1000_0006, 1'b0, 2);

    // WAIT_CYCLES=3: flush in the second ACCESS cycle, then fetch 0x4.
    a0 = ack_cnt[1];
    req[1] = 1'b1; addr[1] = 32'h40;
    @(posedge clk); #1; req[1] = 1'b0;
    @(posedge clk); #1; flush[1] = 1'b1;
    @(posedge clk); #1; flush[1] = 1'b0;
    fetch(1, 32'h4, 32'h1000_0001, 1'b0);
    chk("flush_w3_ack_count", 64'(ack_cnt[1] - a0), 64'd1);

    // Reset during ACCESS: no ack, outputs cleared.
    a0 = ack_cnt[1];
    req[1] = 1'b1; addr[1] = 32'h20;
    @(posedge clk); #1; req[1] = 1'b0; rst_n[1] = 1'b0;
    @(posedge clk); #1; rst_n[1] = 1'b1;
    @(negedge clk);
    chk_reset(1, "reset_in_access_outputs");
    repeat (6) @(posedge clk);
    #1;
    chk("reset_in_access_ack_count", 64'(ack_cnt[1] - a0), 64'd0);

    // load_start wins over fetch_req; throttled load of new contents.
    load(0, 32'h2000_0000, 1'b1, 1'b1);
    fetch(0, 32'h0, 32'h2000_0000, 1'b0);
    fetch(0, 32'h8, 32'h2000_0002, 1'b0);

    // Reset after 10 load words: earlier words kept, later ones untouched.
    ls[1] = 1'b1;
    @(posedge clk); #1; ls[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      lv[1] = 1'b1;
      ld[1] = 32'h3000_0000 + i;
      @(posedge clk); #1;
    end
    lv[1] = 1'b0;
    rst_n[1] = 1'b0;
    @(posedge clk); #1; rst_n[1] = 1'b1;
    @(negedge clk);
    chk_reset(1, "reset_in_load_outputs");
    @(posedge clk); #1;
    fetch(1, 32'h24, 32'h3000_0009, 1'b0);
    fetch(1, 32'h28, 32'h1000_000A, 1'b0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
